// File: rtl/mips_multicycle_control_if.sv
// Memory handshake bus between the multicycle control FSM and the memory port.
// Rev 1.0 - initial release.
`default_nettype none

interface mips_multicycle_control_if;
  logic mem_req;
  logic mem_ready;
  logic IorD;
  logic MemWrite;

  modport master (
    output mem_req,
    output IorD,
    output MemWrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  IorD,
    input  MemWrite,
    output mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional feature macro: CTRL_BNE_EN (adds bne through the BRANCH state). Rev 1.0.
`default_nettype none

module mips_multicycle_control (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [5:0]           opcode,
  input  wire logic [5:0]           funct,
  mips_multicycle_control_if.master mem,
  output logic                      IRWrite,
  output logic                      RegWrite,
  output logic                      RegDst,
  output logic                      MemtoReg,
  output logic                      ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [1:0]                ALUOp,
  output logic [1:0]                PCSrc,
  output logic                      PCWrite,
  output logic                      Branch,
  output logic                      BranchNe,
  output logic                      illegal_op,
  output logic [3:0]                state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_JR      = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       ior_d;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
  } ctrl_t;

  // Moore decode; FETCH's IRWrite/PCWrite are added combinationally from mem_ready.
  function automatic ctrl_t decode(state_e s, logic bne);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.ior_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.ior_d     = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_JR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = ~bne;
        c.branch_ne = bne;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_d;
  logic   is_bne;

  always_comb begin
`ifdef CTRL_BNE_EN
    is_bne = (opcode == OP_BNE);
`else
    is_bne = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:   if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem.mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
    // Opcode is already stable when leaving DECODE, so BRANCH's flavour can be registered.
    ctrl_d = decode(state_d, is_bne);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign mem.mem_req  = ctrl_q.mem_req;
  assign mem.IorD     = ctrl_q.ior_d;
  assign mem.MemWrite = ctrl_q.mem_write;
  assign IRWrite      = (state_q == S_FETCH) & mem.mem_ready;
  assign PCWrite      = ctrl_q.pc_write | IRWrite;
  assign RegWrite     = ctrl_q.reg_write;
  assign RegDst       = ctrl_q.reg_dst;
  assign MemtoReg     = ctrl_q.mem_to_reg;
  assign ALUSrcA      = ctrl_q.alu_src_a;
  assign ALUSrcB      = ctrl_q.alu_src_b;
  assign ALUOp        = ctrl_q.alu_op;
  assign PCSrc        = ctrl_q.pc_src;
  assign Branch       = ctrl_q.branch;
  assign BranchNe     = ctrl_q.branch_ne;
  assign illegal_op   = illegal_d;
  assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for the multicycle MIPS control FSM.
`default_nettype none

module tb_mips_multicycle_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCWrite;
  logic       Branch, BranchNe, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  int         n_tests = 0;
  int         n_fail = 0;

  mips_multicycle_control_if mem_bus ();

  mips_multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .mem        (mem_bus.master),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .BranchNe   (BranchNe),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_bus.mem_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({state, mem_bus.mem_req, ALUSrcB, IRWrite, PCWrite, RegWrite, mem_bus.MemWrite, mem_bus.IorD, ALUSrcA}
        !== {4'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%0d req=%b srcb=%b ir=%b pc=%b rw=%b mw=%b expected st=0 req=1 srcb=01 rest 0",
               state, mem_bus.mem_req, ALUSrcB, IRWrite, PCWrite, RegWrite, mem_bus.MemWrite);
    end
    step();
    mem_bus.mem_ready = 1'b1;
    #1;
    n_tests++;
    if ({state, IRWrite, PCWrite} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_fetch_ready: got st=%0d ir=%b pc=%b expected st=0 ir=1 pc=1", state, IRWrite, PCWrite);
    end
    rst = 1'b1;
    opcode = 6'b000010;
    step();
    n_tests++;
    if ({state, ALUSrcB, IRWrite} !== {4'd1, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_to_decode: got st=%0d srcb=%b ir=%b expected st=1 srcb=11 ir=0", state, ALUSrcB, IRWrite);
    end
    step();
    n_tests++;
    if ({state, PCWrite, PCSrc, mem_bus.mem_req} !== {4'd12, 1'b1, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL jump_state: got st=%0d pcw=%b pcsrc=%b req=%b expected st=12 pcw=1 pcsrc=10 req=0",
               state, PCWrite, PCSrc, mem_bus.mem_req);
    end
    step();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL jump_return: got st=%0d expected 0", state);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [1:0] exp_wb [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
    logic [1:0] exp_mi [6] = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10};
    opcode = 6'b100011;
    mem_bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({state, RegWrite, MemtoReg, mem_bus.mem_req, mem_bus.IorD} !== {exp_st[i], exp_wb[i], exp_mi[i]}) begin
        n_fail++;
        $display("FAIL lw_cycle%0d: got st=%0d rw=%b m2r=%b req=%b iord=%b expected st=%0d rw/m2r=%b req/iord=%b",
                 i, state, RegWrite, MemtoReg, mem_bus.mem_req, mem_bus.IorD, exp_st[i], exp_wb[i], exp_mi[i]);
      end
      if (i == 2) begin
        n_tests++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== {1'b1, 2'b10, 2'b00}) begin
          n_fail++;
          $display("FAIL lw_memadr_alu: got a=%b b=%b op=%b expected a=1 b=10 op=00", ALUSrcA, ALUSrcB, ALUOp);
        end
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_sw_stall();
    opcode = 6'b101011;
    mem_bus.mem_ready = 1'b1;
    step();
    step();
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) mem_bus.mem_ready = 1'b1;
      #1;
      n_tests++;
      if ({state, mem_bus.MemWrite, mem_bus.mem_req, mem_bus.IorD, RegWrite} !== {4'd5, 1'b1, 1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL sw_wait%0d: got st=%0d mw=%b req=%b iord=%b rw=%b expected st=5 mw=1 req=1 iord=1 rw=0",
                 i, state, mem_bus.MemWrite, mem_bus.mem_req, mem_bus.IorD, RegWrite);
      end
    end
    step();
    n_tests++;
    if ({state, mem_bus.MemWrite} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_done: got st=%0d mw=%b expected st=0 mw=0", state, mem_bus.MemWrite);
    end
  endtask

  task automatic test_rtype();
    opcode = 6'b000000;
    funct = 6'b100000;
    step();
    step();
    n_tests++;
    if ({state, ALUSrcA, ALUSrcB, ALUOp, RegWrite} !== {4'd6, 1'b1, 2'b00, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL rtype_execute: got st=%0d a=%b b=%b op=%b rw=%b expected st=6 a=1 b=00 op=10 rw=0",
               state, ALUSrcA, ALUSrcB, ALUOp, RegWrite);
    end
    step();
    n_tests++;
    if ({state, RegDst, RegWrite, MemtoReg} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rtype_aluwb: got st=%0d dst=%b rw=%b m2r=%b expected st=7 dst=1 rw=1 m2r=0",
               state, RegDst, RegWrite, MemtoReg);
    end
    step();
    funct = 6'b001000;
    step();
    step();
    n_tests++;
    if ({state, PCWrite, PCSrc, ALUOp, ALUSrcA} !== {4'd8, 1'b1, 2'b00, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL jr_state: got st=%0d pcw=%b pcsrc=%b op=%b a=%b expected st=8 pcw=1 pcsrc=00 op=10 a=1",
               state, PCWrite, PCSrc, ALUOp, ALUSrcA);
    end
    step();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL jr_return: got st=%0d expected 0", state);
    end
  endtask

  task automatic test_addi();
    opcode = 6'b001000;
    funct = 6'b000000;
    step();
    step();
    n_tests++;
    if ({state, ALUSrcA, ALUSrcB, ALUOp} !== {4'd10, 1'b1, 2'b10, 2'b00}) begin
      n_fail++;
      $display("FAIL addi_ex: got st=%0d a=%b b=%b op=%b expected st=10 a=1 b=10 op=00", state, ALUSrcA, ALUSrcB, ALUOp);
    end
    step();
    n_tests++;
    if ({state, RegWrite, RegDst, MemtoReg} !== {4'd11, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL addi_wb: got st=%0d rw=%b dst=%b m2r=%b expected st=11 rw=1 dst=0 m2r=0", state, RegWrite, RegDst, MemtoReg);
    end
    step();
  endtask

  task automatic test_branch();
    opcode = 6'b000100;
    step();
    step();
    n_tests++;
    if ({state, Branch, BranchNe, ALUOp, PCSrc, ALUSrcA} !== {4'd9, 1'b1, 1'b0, 2'b01, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL beq_branch: got st=%0d br=%b bne=%b op=%b pcsrc=%b a=%b expected st=9 br=1 bne=0 op=01 pcsrc=01 a=1",
               state, Branch, BranchNe, ALUOp, PCSrc, ALUSrcA);
    end
    step();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL beq_return: got st=%0d expected 0", state);
    end
    opcode = 6'b000101;
    step();
`ifdef CTRL_BNE_EN
    n_tests++;
    if ({state, illegal_op} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL bne_decode: got st=%0d ill=%b expected st=1 ill=0", state, illegal_op);
    end
    step();
    n_tests++;
    if ({state, Branch, BranchNe, ALUOp} !== {4'd9, 1'b0, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL bne_branch: got st=%0d br=%b bne=%b op=%b expected st=9 br=0 bne=1 op=01", state, Branch, BranchNe, ALUOp);
    end
`else
    n_tests++;
    if ({state, illegal_op, BranchNe} !== {4'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bne_illegal: got st=%0d ill=%b bne=%b expected st=1 ill=1 bne=0", state, illegal_op, BranchNe);
    end
`endif
    step();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL bne_return: got st=%0d expected 0", state);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    n_tests++;
    if (illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_in_fetch: got %b expected 0", illegal_op);
    end
    step();
    n_tests++;
    if ({state, illegal_op, RegWrite, mem_bus.MemWrite, PCWrite} !== {4'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_decode: got st=%0d ill=%b rw=%b mw=%b pcw=%b expected st=1 ill=1 rw=0 mw=0 pcw=0",
               state, illegal_op, RegWrite, mem_bus.MemWrite, PCWrite);
    end
    mem_bus.mem_ready = 1'b0;
    step();
    n_tests++;
    if ({state, illegal_op, IRWrite, PCWrite} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_return: got st=%0d ill=%b ir=%b pcw=%b expected st=0 ill=0 ir=0 pcw=0",
               state, illegal_op, IRWrite, PCWrite);
    end
    step();
    n_tests++;
    if ({state, mem_bus.mem_req} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_stall: got st=%0d req=%b expected st=0 req=1", state, mem_bus.mem_req);
    end
    mem_bus.mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    opcode = 6'b101011;
    step();
    step();
    mem_bus.mem_ready = 1'b0;
    step();
    step();
    n_tests++;
    if ({state, mem_bus.MemWrite} !== {4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_pre: got st=%0d mw=%b expected st=5 mw=1", state, mem_bus.MemWrite);
    end
    #3 rst = 1'b0;
    #1;
    n_tests++;
    if ({state, mem_bus.MemWrite, mem_bus.mem_req, mem_bus.IorD} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_async: got st=%0d mw=%b req=%b iord=%b expected st=0 mw=0 req=1 iord=0",
               state, mem_bus.MemWrite, mem_bus.mem_req, mem_bus.IorD);
    end
    mem_bus.mem_ready = 1'b1;
    opcode = 6'b000010;
    rst = 1'b1;
    step();
    n_tests++;
    if ({state, mem_bus.MemWrite, RegWrite, PCWrite} !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_release: got st=%0d mw=%b rw=%b pcw=%b expected st=1 mw=0 rw=0 pcw=0",
               state, mem_bus.MemWrite, RegWrite, PCWrite);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_addi();
    test_branch();
    test_illegal();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
